// File: rtl/bin_ascii_seq_pkg.sv
// bin_ascii_pkg: shared constants, FSM states and helpers for the binary to ASCII converter
package bin_ascii_pkg;
   localparam logic [6:0] ASCII_ZERO = 7'h30;
   localparam logic [6:0] ASCII_SPACE = 7'h20;
   localparam logic [2:0] ASCII_HI = 3'b011;
   localparam logic [3:0] BCD_CORR_THRESH = 4'd5;
   localparam logic [3:0] BCD_CORR_ADD = 4'd3;
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
   function automatic longint unsigned pow10(input int n);
      longint unsigned r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction
endpackage

// File: rtl/bin_ascii_seq_if.sv
// bin_ascii_seq_if: input and output valid/ready channels plus busy status of the converter
interface bin_ascii_seq_if #(
   parameter int WIDTH = 8,
   parameter int DIGITS = 3
);
   logic in_valid;
   logic in_ready;
   logic [WIDTH-1:0] in_data;
   logic out_valid;
   logic out_ready;
   logic [7*DIGITS-1:0] out_ascii;
   logic busy;
   modport master (
      output in_valid, in_data, out_ready,
      input in_ready, out_valid, out_ascii, busy
   );
   modport slave (
      input in_valid, in_data, out_ready,
      output in_ready, out_valid, out_ascii, busy
   );
endinterface

// File: rtl/bin_ascii_seq_bcd_corr_digit.sv
// bcd_corr_digit: double-dabble add-3 correction of one BCD nibble
module bcd_corr_digit
   import bin_ascii_pkg::*;
(
   input logic [3:0] nib,
   output logic [3:0] corr
);
   assign corr = nib >= BCD_CORR_THRESH ? nib + BCD_CORR_ADD : nib;
endmodule

// File: rtl/bin_ascii_seq.sv
// bin_ascii_seq: bit-serial double-dabble binary to ASCII decimal converter; define BIN_ASCII_BLANK_LZ_EN to blank leading zeros
module bin_ascii_seq
   import bin_ascii_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGITS = 3,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input logic clk,
   input logic rst,
   bin_ascii_seq_if.slave bus
);
   state_t state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] sh;
   logic [4*DIGITS-1:0] bcd, corr;
   logic accept;

   if (WIDTH < 1 || WIDTH > 32 || pow10(DIGITS) < (64'd1 << WIDTH)) begin : g_bad_params
      $error("bin_ascii_seq: DIGITS cannot represent every WIDTH-bit value");
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_corr
      bcd_corr_digit u_corr (.nib(bcd[4*i+:4]), .corr(corr[4*i+:4]));
   end

   function automatic logic [7*DIGITS-1:0] fmt(input logic [4*DIGITS-1:0] b);
      logic [7*DIGITS-1:0] r;
`ifdef BIN_ASCII_BLANK_LZ_EN
      logic lead;
      lead = 1'b1;
`endif
      r = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef BIN_ASCII_BLANK_LZ_EN
         lead = lead && b[4*k+:4] == 4'd0 && k != 0;
         r[7*k+:7] = lead ? ASCII_SPACE : {ASCII_HI, b[4*k+:4]};
`else
         r[7*k+:7] = {ASCII_HI, b[4*k+:4]};
`endif
      end
      return r;
   endfunction

   assign bus.in_ready = state == S_IDLE && !rst;
   assign bus.busy = state == S_SHIFT;
   assign bus.out_valid = state == S_DONE;
   assign accept = bus.in_valid && bus.in_ready;

   // state register
   always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;

   // next state: accept, shift until the counter is exhausted, hold result until taken
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: if (accept) state_n = S_SHIFT;
         S_SHIFT: if (cnt == '0) state_n = S_DONE;
         S_DONE: if (bus.out_ready) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // datapath: load operand, one corrected shift per cycle, capture ASCII on DONE entry
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         sh <= '0;
         bcd <= '0;
         bus.out_ascii <= fmt('0);
      end else begin
         if (accept) begin
            sh <= bus.in_data;
            bcd <= '0;
            cnt <= CNT_W'(WIDTH);
         end
         if (state == S_SHIFT && cnt != '0) begin
            bcd <= {corr[4*DIGITS-2:0], sh[WIDTH-1]};
            sh <= sh << 1;
            cnt <= cnt - 1'b1;
         end
         if (state == S_SHIFT && cnt == '0) bus.out_ascii <= fmt(bcd);
      end
   end
endmodule

// File: tb/tb_bin_ascii_seq.sv
// tb_bin_ascii_seq: randomized scoreboard bench for 8-bit/3-digit and 16-bit/5-digit converters
module tb_bin_ascii_seq;
`ifdef BIN_ASCII_BLANK_LZ_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   int rdy_mode = 0;
   logic [34:0] q8[$];
   logic [34:0] q16[$];

   bin_ascii_seq_if #(.WIDTH(8), .DIGITS(3)) b8();
   bin_ascii_seq_if #(.WIDTH(16), .DIGITS(5)) b16();
   bin_ascii_seq #(.WIDTH(8), .DIGITS(3)) dut8 (.clk(clk), .rst(rst), .bus(b8));
   bin_ascii_seq #(.WIDTH(16), .DIGITS(5)) dut16 (.clk(clk), .rst(rst), .bus(b16));

   always #5 clk = ~clk;

   function automatic logic [34:0] model(input longint unsigned v, input int d);
      logic [34:0] r = '0;
      longint unsigned p = 1;
      for (int k = 0; k < d; k++) begin
         r[7*k+:7] = (LZ && k > 0 && v < p) ? 7'h20 : 7'(64'h30 + (v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #2;
      b8.out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   always @(negedge clk) begin
      if (!rst && b8.out_valid && b8.out_ready) begin
         if (q8.size() == 0) chk("dut8 unexpected output", {29'd0, b8.out_ascii}, 64'hffff_ffff);
         else chk("dut8 ascii", {29'd0, b8.out_ascii}, {29'd0, q8.pop_front()});
      end
      if (!rst && b16.out_valid && b16.out_ready) begin
         if (q16.size() == 0) chk("dut16 unexpected output", {29'd0, b16.out_ascii}, 64'hffff_ffff);
         else chk("dut16 ascii", {29'd0, b16.out_ascii}, {29'd0, q16.pop_front()});
      end
   end

   task automatic send8(input logic [7:0] v);
      int t = 0;
      @(posedge clk); #1;
      while (!b8.in_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) chk("dut8 in_ready timeout", 64'(b8.in_ready), 64'd1);
      b8.in_valid = 1'b1;
      b8.in_data = v;
      q8.push_back(model(v, 3));
      @(posedge clk); #1;
      b8.in_valid = 1'b0;
   endtask

   task automatic send16(input logic [15:0] v);
      int t = 0;
      @(posedge clk); #1;
      while (!b16.in_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) chk("dut16 in_ready timeout", 64'(b16.in_ready), 64'd1);
      b16.in_valid = 1'b1;
      b16.in_data = v;
      q16.push_back(model(v, 5));
      @(posedge clk); #1;
      b16.in_valid = 1'b0;
   endtask

   task automatic wait_valid8(output int n);
      n = 0;
      while (!b8.out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic send8_lat(input logic [7:0] v);
      int n;
      send8(v);
      wait_valid8(n);
      chk("dut8 latency", 64'(n), 64'd9);
   endtask

   task automatic wait_idle8();
      int n = 0;
      while (!b8.in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("dut8 return to idle", 64'(b8.in_ready), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      b8.in_valid = 1'b0;
      b8.in_data = '0;
      b8.out_ready = 1'b1;
      b16.in_valid = 1'b0;
      b16.in_data = '0;
      b16.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", 64'(b8.in_ready), 64'd0);
      chk("reset out_valid", 64'(b8.out_valid), 64'd0);
      chk("reset busy", 64'(b8.busy), 64'd0);
      chk("reset ascii8", {43'd0, b8.out_ascii}, {29'd0, model(0, 3)});
      chk("reset ascii16", {29'd0, b16.out_ascii}, {29'd0, model(0, 5)});
      rst = 1'b0;
      #1;
      chk("post-reset in_ready", 64'(b8.in_ready), 64'd1);
      send8_lat(8'd255);
      send8(8'd100);
      send8(8'd0);
      send16(16'd65535);
      n = 0;
      while (!b16.out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("dut16 latency", 64'(n), 64'd17);
      send16(16'd10000);
      wait_idle8();
      rdy_mode = 2;
      send8(8'd42);
      wait_valid8(n);
      b8.in_valid = 1'b1;
      b8.in_data = 8'd99;
      for (int i = 0; i < 10; i++) begin
         chk("stall out_valid", 64'(b8.out_valid), 64'd1);
         chk("stall ascii", {43'd0, b8.out_ascii}, {29'd0, model(42, 3)});
         chk("stall in_ready", 64'(b8.in_ready), 64'd0);
         @(posedge clk); #1;
      end
      b8.in_valid = 1'b0;
      rdy_mode = 0;
      n = 0;
      while (b8.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("release in_ready", 64'(b8.in_ready), 64'd1);
      send8(8'd199);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midop busy", 64'(b8.busy), 64'd0);
      chk("midop out_valid", 64'(b8.out_valid), 64'd0);
      chk("midop ascii", {43'd0, b8.out_ascii}, {29'd0, model(0, 3)});
      q8.delete();
      rst = 1'b0;
      #1;
      chk("midop in_ready", 64'(b8.in_ready), 64'd1);
      send8_lat(8'd7);
      rdy_mode = 1;
      for (int v = 0; v < 256; v++) send8(8'(v));
      n = 0;
      while ((q8.size() != 0 || q16.size() != 0) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      chk("scoreboard drained", 64'(q8.size() + q16.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/bin_ascii_seq.md
Name: bin_ascii_seq

Overview:
- Parametrised, sequential binary-to-ASCII decimal converter using iterative shift-add-3 (double dabble).
- Processes one input bit per clock instead of an unrolled correction-cell array.
- Arbitrary input width and digit count, valid/ready handshake on both sides.
- Sits between the adder result register and the UART/display character path; each digit is a 7-bit ASCII code.

Parameters:
- WIDTH, 8, binary input width in bits (legal range 1..32).
- DIGITS, 3, number of decimal digits produced. Must satisfy 10^DIGITS >= 2^WIDTH; elaboration fails otherwise.
- CNT_W, $clog2(WIDTH+1), width of the bit counter (derived; do not override).

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- in_valid, in, 1, in_data is valid.
- in_ready, out, 1, block can accept a new value.
- in_data, in, WIDTH, unsigned binary value to convert.
- out_valid, out, 1, out_ascii holds a completed result.
- out_ready, in, 1, consumer accepts out_ascii.
- out_ascii, out, 7*DIGITS, ASCII digits. Digit k (k=0 is units) occupies bits [7k+6:7k].
- busy, out, 1, high while in SHIFT state.

Behaviour:
- FSM states: IDLE, SHIFT, DONE. Encoding comes from the package.
- Reset (rst=1 at an edge): state=IDLE, bit counter=0, BCD register=0, shift register=0, out_valid=0, busy=0.
  - out_ascii reset value: every digit 7'h30.
  - rst has priority over every other event, including mid-SHIFT and during DONE with out_ready=1. The partial result is discarded and nothing is emitted.
- in_ready = (state==IDLE) & ~rst. This is combinational from state.
- IDLE: on in_valid & in_ready:
  - latch in_data into the shift register;
  - clear the BCD register (4*DIGITS bits);
  - counter=WIDTH;
  - go to SHIFT.
  - in_valid without in_ready is ignored; no buffering.
- SHIFT: one iteration per cycle.
  - Each BCD nibble >=5 gets +3.
  - Then {bcd, shift} is shifted left by 1; the shift-register MSB enters the BCD LSB.
  - Counter decrements; on the cycle the counter reaches 0, go to DONE.
  - in_ready=0 throughout; in_valid is ignored.
- Latency: the accept edge is E0 and shifts occur on E1..E_WIDTH. out_valid is high after E_WIDTH+1, i.e. exactly WIDTH+1 clocks from accept to out_valid. For WIDTH=8 that is 9.
- DONE:
  - out_ascii = {3'b011, nibble} per digit. It is registered and updated on the DONE entry edge.
  - out_valid=1, held stable with out_ascii until out_ready=1.
  - On an edge with out_valid & out_ready: go to IDLE and drop out_valid. in_ready rises the following cycle; there is no same-cycle re-accept.
- out_ascii keeps its last value after handoff until the next DONE entry.
- Values wider than DIGITS can represent cannot occur, given the parameter check.
- WIDTH=1: a single SHIFT cycle; the result is "0…0" or "0…1".

Optional Feature:
- Macro: BIN_ASCII_BLANK_LZ_EN.
- Defined: leading zero digits are emitted as ASCII space 7'h20. The units digit is always a numeral, so 0 gives "  0" for DIGITS=3. Reset value of out_ascii becomes spaces, with the units digit 7'h30.
- Undefined: all digits are numerals 7'h30..7'h39, and leading zeros are shown.

Decomposition:
- Package bin_ascii_pkg holds:
  - ASCII_ZERO=7'h30, ASCII_SPACE=7'h20, ASCII_HI=3'b011;
  - FSM state localparams S_IDLE/S_SHIFT/S_DONE;
  - BCD_CORR_THRESH=4'd5, BCD_CORR_ADD=4'd3.
- Sub-module bcd_corr_digit: one nibble in, nibble+3 if >=5, else unchanged. It is combinational and instantiated DIGITS times via generate.

Test Plan:
- WIDTH=8, DIGITS=3, in_data=8'd255, out_ready=1 -> out_valid exactly 9 cycles after accept, out_ascii={7'h32,7'h35,7'h35} ("255").
- in_data=8'd100, then 8'd0 back-to-back -> "100" = {7'h31,7'h30,7'h30}; then "000", or "  0" = {7'h20,7'h20,7'h30} with BIN_ASCII_BLANK_LZ_EN.
- Backpressure: in_data=8'd42, out_ready=0 for 10 cycles -> out_valid stays 1, out_ascii "042" stable, in_ready=0, and a new in_valid is ignored. out_ready=1 -> IDLE, in_ready=1 the next cycle.
- Reset mid-op: accept 8'd199, assert rst on the 4th SHIFT cycle -> the next cycle shows state IDLE, out_valid=0, out_ascii at its reset value, busy=0. A subsequent 8'd7 converts to "007" in 9 cycles.
- WIDTH=16, DIGITS=5, in_data=16'd65535 -> "65535" after 17 cycles. in_data=16'd10000 -> "10000".
- Exhaustive WIDTH=8 sweep of 0..255 with random out_ready gaps -> every result matches the reference decimal model. No result is dropped or duplicated.
